// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: PLL reset hold, synchronised lock qualification with timeout/retry,
// staggered clock-gate enable, and teardown/relock on lock loss or request.

module pll_gate_stage #(
  parameter int IDX   = 0,
  parameter int DELAY = 1,
  parameter int TW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          gate_on,
  input  logic          run,
  input  logic [TW-1:0] timer,
  output logic          en
);
  localparam logic [TW:0] AT = (TW+1)'(DELAY*IDX);

  logic en_nxt;

  // timer+1 > AT is timer >= AT without a constant compare when AT is zero
  assign en_nxt = run | (gate_on & (({1'b0, timer} + 1'b1) > AT));

  always_ff @(posedge clk or posedge rst)
    if (rst) en <= 1'b0;
    else     en <= en_nxt;
endmodule

module pll_lock_sequencer #(
  parameter int RST_HOLD_CYCLES     = 64,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int GATE_DELAY_CYCLES   = 16,
  parameter int NUM_GATES           = 5,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                 clkin1,
  input  logic                 pll_rst,
  input  logic                 pll_lock,
  input  logic                 relock_req,
  output logic                 pll_core_rst,
  output logic [NUM_GATES-1:0] gate_en,
  output logic                 ready,
  output logic                 fail,
  output logic [3:0]           retry_cnt,
  output logic [7:0]           relock_cnt
);
  localparam int GATE_SPAN = GATE_DELAY_CYCLES*(NUM_GATES-1);
  localparam int M0 = (RST_HOLD_CYCLES > LOCK_STABLE_CYCLES) ? RST_HOLD_CYCLES : LOCK_STABLE_CYCLES;
  localparam int M1 = (M0 > LOCK_TIMEOUT_CYCLES) ? M0 : LOCK_TIMEOUT_CYCLES;
  localparam int M2 = (M1 > GATE_SPAN+1) ? M1 : GATE_SPAN+1;
  localparam int TW = $clog2(M2) + 1;

  localparam logic [TW-1:0] HOLD_LAST    = TW'(RST_HOLD_CYCLES-1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES-1);
  localparam logic [TW-1:0] STABLE_LAST  = TW'(LOCK_STABLE_CYCLES-1);
  localparam logic [TW-1:0] GATE_LAST    = TW'(GATE_SPAN);
  localparam logic [3:0]    RETRY_MAX    = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET, S_WAIT_LOCK, S_STABLE, S_GATE_ON, S_RUN, S_FAIL
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [3:0]    retry_nxt;
  logic [7:0]    relock_nxt;
  logic [1:0]    lock_pipe;
  logic          lock_s;
  logic          core_rst_nxt, ready_nxt, fail_nxt;

  always_ff @(posedge clkin1 or posedge pll_rst)
    if (pll_rst) lock_pipe <= 2'b00;
    else         lock_pipe <= {lock_pipe[0], pll_lock};

  assign lock_s = lock_pipe[1];

  always_ff @(posedge clkin1 or posedge pll_rst)
    if (pll_rst) begin
      state        <= S_RESET;
      timer        <= '0;
      retry_cnt    <= 4'd0;
      relock_cnt   <= 8'd0;
      pll_core_rst <= 1'b1;
      ready        <= 1'b0;
      fail         <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      retry_cnt    <= retry_nxt;
      relock_cnt   <= relock_nxt;
      pll_core_rst <= core_rst_nxt;
      ready        <= ready_nxt;
      fail         <= fail_nxt;
    end

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    retry_nxt  = retry_cnt;
    relock_nxt = relock_cnt;
    if (relock_req) begin
      // request outranks a coincident lock loss, so it is never counted as a relock
      state_nxt = S_RESET;
      timer_nxt = '0;
      retry_nxt = 4'd0;
    end else begin
      case (state)
        S_RESET:
          if (timer == HOLD_LAST) begin
            state_nxt = S_WAIT_LOCK;
            timer_nxt = '0;
          end else timer_nxt = timer + 1'b1;
        S_WAIT_LOCK:
          if (lock_s) begin
            state_nxt = S_STABLE;
            timer_nxt = '0;
          end else if (timer == TIMEOUT_LAST) begin
            timer_nxt = '0;
            if (retry_cnt < RETRY_MAX) begin
              retry_nxt = retry_cnt + 4'd1;
              state_nxt = S_RESET;
            end else state_nxt = S_FAIL;
          end else timer_nxt = timer + 1'b1;
        S_STABLE:
          if (!lock_s) begin
            state_nxt = S_WAIT_LOCK;
            timer_nxt = '0;
          end else if (timer == STABLE_LAST) begin
            state_nxt = S_GATE_ON;
            timer_nxt = '0;
          end else timer_nxt = timer + 1'b1;
        S_GATE_ON, S_RUN:
          if (!lock_s) begin
            state_nxt  = S_RESET;
            timer_nxt  = '0;
            relock_nxt = (relock_cnt == 8'hFF) ? relock_cnt : relock_cnt + 8'd1;
          end else if (state == S_GATE_ON) begin
            if (timer == GATE_LAST) begin
              state_nxt = S_RUN;
              timer_nxt = '0;
              retry_nxt = 4'd0;
            end else timer_nxt = timer + 1'b1;
          end
        default: ;
      endcase
    end
  end

  always_comb begin
    core_rst_nxt = (state_nxt == S_RESET) || (state_nxt == S_FAIL);
    ready_nxt    = (state_nxt == S_RUN);
    fail_nxt     = (state_nxt == S_FAIL);
  end

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
    pll_gate_stage #(.IDX(g), .DELAY(GATE_DELAY_CYCLES), .TW(TW)) u_stage (
      .clk     (clkin1),
      .rst     (pll_rst),
      .gate_on (state_nxt == S_GATE_ON),
      .run     (state_nxt == S_RUN),
      .timer   (timer_nxt),
      .en      (gate_en[g])
    );
  end
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed table bench for pll_lock_sequencer: each row drives inputs for n cycles, then
// compares every output against hand-computed values; async reset is checked by hand.

module tb_pll_lock_sequencer;
  logic       clkin1 = 1'b0;
  logic       pll_rst, pll_lock, relock_req;
  logic       pll_core_rst, ready, fail;
  logic [2:0] gate_en;
  logic [3:0] retry_cnt;
  logic [7:0] relock_cnt;

  int n_cmp = 0;
  int n_err = 0;

  pll_lock_sequencer #(
    .RST_HOLD_CYCLES(4), .LOCK_STABLE_CYCLES(8), .LOCK_TIMEOUT_CYCLES(32),
    .GATE_DELAY_CYCLES(2), .NUM_GATES(3), .MAX_RETRIES(2)
  ) dut (
    .clkin1(clkin1), .pll_rst(pll_rst), .pll_lock(pll_lock), .relock_req(relock_req),
    .pll_core_rst(pll_core_rst), .gate_en(gate_en), .ready(ready), .fail(fail),
    .retry_cnt(retry_cnt), .relock_cnt(relock_cnt)
  );

  always #5 clkin1 = ~clkin1;

  typedef struct {
    int         n;
    logic       lock;
    logic       req;
    logic       core;
    logic [2:0] gate;
    logic       rdy;
    logic       fl;
    logic [3:0] rty;
    logic [7:0] rlk;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(int n, logic lock, logic req, logic core, logic [2:0] gate,
                             logic rdy, logic fl, logic [3:0] rty, logic [7:0] rlk);
    vec_t r;
    r.n = n; r.lock = lock; r.req = req; r.core = core; r.gate = gate;
    r.rdy = rdy; r.fl = fl; r.rty = rty; r.rlk = rlk;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input vec_t r);
    chk("pll_core_rst", idx, {7'd0, pll_core_rst}, {7'd0, r.core});
    chk("gate_en",      idx, {5'd0, gate_en},      {5'd0, r.gate});
    chk("ready",        idx, {7'd0, ready},        {7'd0, r.rdy});
    chk("fail",         idx, {7'd0, fail},         {7'd0, r.fl});
    chk("retry_cnt",    idx, {4'd0, retry_cnt},    {4'd0, r.rty});
    chk("relock_cnt",   idx, relock_cnt,           r.rlk);
  endtask

  // inputs change 1 time unit after an edge; relock_req is a single-cycle pulse
  task automatic run_row(input int idx, input vec_t r);
    pll_lock   = r.lock;
    relock_req = r.req;
    for (int k = 0; k < r.n; k++) begin
      @(posedge clkin1); #1;
      relock_req = 1'b0;
    end
    check_all(idx, r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pll_rst = 1'b1; pll_lock = 1'b0; relock_req = 1'b0;
    repeat (3) @(posedge clkin1);
    #1;
    check_all(-1, v(0, 0, 0, 1, 3'b000, 0, 0, 0, 0));

    // bring-up with lock raised 10 cycles after reset release
    tbl.push_back(v( 3, 0, 0, 1, 3'b000, 0, 0, 0, 0));
    tbl.push_back(v( 1, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    tbl.push_back(v( 6, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    tbl.push_back(v(11, 1, 0, 0, 3'b001, 0, 0, 0, 0));
    tbl.push_back(v( 1, 1, 0, 0, 3'b001, 0, 0, 0, 0));
    tbl.push_back(v( 1, 1, 0, 0, 3'b011, 0, 0, 0, 0));
    tbl.push_back(v( 2, 1, 0, 0, 3'b111, 0, 0, 0, 0));
    tbl.push_back(v( 1, 1, 0, 0, 3'b111, 1, 0, 0, 0));
    // one-cycle lock drop in RUN, teardown 3 cycles later, full re-sequence
    tbl.push_back(v( 1, 0, 0, 0, 3'b111, 1, 0, 0, 0));
    tbl.push_back(v( 1, 1, 0, 0, 3'b111, 1, 0, 0, 0));
    tbl.push_back(v( 1, 1, 0, 1, 3'b000, 0, 0, 0, 1));
    tbl.push_back(v( 3, 1, 0, 1, 3'b000, 0, 0, 0, 1));
    tbl.push_back(v( 1, 1, 0, 0, 3'b000, 0, 0, 0, 1));
    tbl.push_back(v( 9, 1, 0, 0, 3'b001, 0, 0, 0, 1));
    tbl.push_back(v( 4, 1, 0, 0, 3'b111, 0, 0, 0, 1));
    tbl.push_back(v( 1, 1, 0, 0, 3'b111, 1, 0, 0, 1));
    // relock_req from RUN, then a glitch at stable count 5 delays GATE_ON by 7 cycles
    tbl.push_back(v( 1, 1, 1, 1, 3'b000, 0, 0, 0, 1));
    tbl.push_back(v( 4, 1, 0, 0, 3'b000, 0, 0, 0, 1));
    tbl.push_back(v( 4, 1, 0, 0, 3'b000, 0, 0, 0, 1));
    tbl.push_back(v( 1, 0, 0, 0, 3'b000, 0, 0, 0, 1));
    tbl.push_back(v( 2, 1, 0, 0, 3'b000, 0, 0, 0, 1));
    tbl.push_back(v( 2, 1, 0, 0, 3'b000, 0, 0, 0, 1));
    tbl.push_back(v( 6, 1, 0, 0, 3'b000, 0, 0, 0, 1));
    tbl.push_back(v( 1, 1, 0, 0, 3'b001, 0, 0, 0, 1));
    tbl.push_back(v( 5, 1, 0, 0, 3'b111, 1, 0, 0, 1));
    // lock held low: two retries of 4+32 cycles, then FAIL
    tbl.push_back(v( 1, 0, 1, 1, 3'b000, 0, 0, 0, 1));
    tbl.push_back(v( 4, 0, 0, 0, 3'b000, 0, 0, 0, 1));
    tbl.push_back(v(31, 0, 0, 0, 3'b000, 0, 0, 0, 1));
    tbl.push_back(v( 1, 0, 0, 1, 3'b000, 0, 0, 1, 1));
    tbl.push_back(v(35, 0, 0, 0, 3'b000, 0, 0, 1, 1));
    tbl.push_back(v( 1, 0, 0, 1, 3'b000, 0, 0, 2, 1));
    tbl.push_back(v(35, 0, 0, 0, 3'b000, 0, 0, 2, 1));
    tbl.push_back(v( 1, 0, 0, 1, 3'b000, 0, 1, 2, 1));
    tbl.push_back(v( 5, 0, 0, 1, 3'b000, 0, 1, 2, 1));
    // relock_req out of FAIL, bring-up, then relock_req coinciding with lock loss
    tbl.push_back(v( 1, 0, 1, 1, 3'b000, 0, 0, 0, 1));
    tbl.push_back(v( 3, 0, 0, 1, 3'b000, 0, 0, 0, 1));
    tbl.push_back(v( 1, 0, 0, 0, 3'b000, 0, 0, 0, 1));
    tbl.push_back(v(16, 1, 0, 0, 3'b111, 1, 0, 0, 1));
    tbl.push_back(v( 2, 0, 0, 0, 3'b111, 1, 0, 0, 1));
    tbl.push_back(v( 1, 0, 1, 1, 3'b000, 0, 0, 0, 1));
    // re-sequence up to gate_en=011
    tbl.push_back(v(15, 1, 0, 0, 3'b011, 0, 0, 0, 1));

    pll_rst = 1'b0;
    foreach (tbl[i]) run_row(i, tbl[i]);

    // async reset mid-GATE_ON, checked before the next clock edge
    pll_rst = 1'b1;
    #2;
    check_all(100, v(0, 1, 0, 1, 3'b000, 0, 0, 0, 0));
    repeat (2) @(posedge clkin1);
    #1;
    check_all(101, v(0, 1, 0, 1, 3'b000, 0, 0, 0, 0));

    // relock_req in RESET restarts the hold timer
    pll_rst = 1'b0;
    run_row(102, v(2, 1, 0, 1, 3'b000, 0, 0, 0, 0));
    run_row(103, v(1, 1, 1, 1, 3'b000, 0, 0, 0, 0));
    run_row(104, v(3, 1, 0, 1, 3'b000, 0, 0, 0, 0));
    run_row(105, v(1, 1, 0, 0, 3'b000, 0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
